// File: rtl/plm_bank_arbiter_if.sv
// Request/ack, bank command and read-response bundle between the consumer fabric,
// plm_bank_arbiter and the PLM bank array (master = consumers + banks, slave = arbiter).
interface plm_bank_arbiter_if #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 2
);
  localparam int BANK_BITS       = (NBANKS > 1) ? $clog2(NBANKS) : 0;
  localparam int BADDR_WIDTH     = ADDR_WIDTH - BANK_BITS;
  localparam int REQ_WIDTH       = ADDR_WIDTH + VALUE_WIDTH + 2;
  localparam int PLM_INPUT_WIDTH = BADDR_WIDTH + VALUE_WIDTH + 1;

  logic [REQ_WIDTH-1:0]       requests   [NCONSUMERS];
  logic [NCONSUMERS-1:0]      ack;
  logic [PLM_INPUT_WIDTH-1:0] out        [NBANKS];
  logic [NBANKS-1:0]          out_en;
  logic [VALUE_WIDTH-1:0]     plm_rdata  [NBANKS];
  logic [NCONSUMERS-1:0]      resp_valid;
  logic [VALUE_WIDTH-1:0]     resp_data  [NCONSUMERS];

  modport master (
    output requests, plm_rdata,
    input  ack, out, out_en, resp_valid, resp_data
  );

  modport slave (
    input  requests, plm_rdata,
    output ack, out, out_en, resp_valid, resp_data
  );
endinterface

// File: rtl/plm_bank_arbiter.sv
// Per-bank round-robin arbiter: combinational ack, registered bank command next cycle,
// read data routed back to the owner 2 cycles after ack; losers are simply not acked.
module plm_bank_arbiter #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 2
) (
  input logic               clk,
  input logic               reset,
  plm_bank_arbiter_if.slave bus
);
  localparam int BANK_BITS       = (NBANKS > 1) ? $clog2(NBANKS) : 0;
  localparam int BADDR_WIDTH     = ADDR_WIDTH - BANK_BITS;
  localparam int REQ_WIDTH       = ADDR_WIDTH + VALUE_WIDTH + 2;
  localparam int PLM_INPUT_WIDTH = BADDR_WIDTH + VALUE_WIDTH + 1;
  localparam int PTR_W           = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

  logic [NCONSUMERS-1:0]      req_vld;
  logic [ADDR_WIDTH-1:0]      req_addr  [NCONSUMERS];
  logic [ADDR_WIDTH-1:0]      req_bank  [NCONSUMERS];
  logic [PLM_INPUT_WIDTH-1:0] req_cmd   [NCONSUMERS];

  logic [NBANKS-1:0]          win_vld;
  logic [PTR_W-1:0]           win_id    [NBANKS];
  logic [NCONSUMERS-1:0]      ack_c;

  logic [PTR_W-1:0]           ptr_q       [NBANKS];
  logic [PTR_W-1:0]           ptr_d       [NBANKS];
  logic [PLM_INPUT_WIDTH-1:0] out_q       [NBANKS];
  logic [PLM_INPUT_WIDTH-1:0] out_d       [NBANKS];
  logic [NBANKS-1:0]          out_en_q, out_en_d;
  logic [PTR_W-1:0]           cmd_owner_q [NBANKS];
  logic [PTR_W-1:0]           cmd_owner_d [NBANKS];
  logic [NBANKS-1:0]          rd_pend_q, rd_pend_d;
  logic [PTR_W-1:0]           tag_owner_q [NBANKS];
  logic [PTR_W-1:0]           tag_owner_d [NBANKS];

  logic [NCONSUMERS-1:0]      resp_vld;
  logic [VALUE_WIDTH-1:0]     resp_dat  [NCONSUMERS];
  logic [NCONSUMERS-1:0]      tag_clash;

  // Bank select is the low address bits; the mask is zero for a single bank.
  always_comb begin
    for (int c = 0; c < NCONSUMERS; c++) begin
      req_vld[c]  = bus.requests[c][REQ_WIDTH-1];
      req_addr[c] = bus.requests[c][VALUE_WIDTH +: ADDR_WIDTH];
      req_bank[c] = req_addr[c] & ADDR_WIDTH'(NBANKS - 1);
      req_cmd[c]  = {bus.requests[c][REQ_WIDTH-2],
                     BADDR_WIDTH'(req_addr[c] >> BANK_BITS),
                     bus.requests[c][VALUE_WIDTH-1:0]};
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int b = 0; b < NBANKS; b++) begin
      win_vld[b] = 1'b0;
      win_id[b]  = '0;
      // Walk from the farthest candidate back to ptr so the nearest one wins.
      for (int k = NCONSUMERS - 1; k >= 0; k--) begin
        idx = (int'(ptr_q[b]) + k) % NCONSUMERS;
        if (reset && req_vld[idx] && (req_bank[idx] == ADDR_WIDTH'(b))) begin
          win_vld[b] = 1'b1;
          win_id[b]  = PTR_W'(idx);
        end
      end
    end
  end

  always_comb begin
    ack_c = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (win_vld[b]) begin
        ack_c[win_id[b]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      ptr_d[b]       = ptr_q[b];
      out_d[b]       = out_q[b];
      cmd_owner_d[b] = cmd_owner_q[b];
      out_en_d[b]    = win_vld[b];
      if (win_vld[b]) begin
        ptr_d[b]       = (win_id[b] == PTR_W'(NCONSUMERS - 1)) ? '0 : win_id[b] + 1'b1;
        out_d[b]       = req_cmd[win_id[b]];
        cmd_owner_d[b] = win_id[b];
      end
      rd_pend_d[b]   = out_en_q[b] && !out_q[b][PLM_INPUT_WIDTH-1];
      tag_owner_d[b] = cmd_owner_q[b];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_en_q  <= '0;
      rd_pend_q <= '0;
      for (int b = 0; b < NBANKS; b++) begin
        ptr_q[b]       <= '0;
        out_q[b]       <= '0;
        cmd_owner_q[b] <= '0;
        tag_owner_q[b] <= '0;
      end
    end else begin
      out_en_q  <= out_en_d;
      rd_pend_q <= rd_pend_d;
      for (int b = 0; b < NBANKS; b++) begin
        ptr_q[b]       <= ptr_d[b];
        out_q[b]       <= out_d[b];
        cmd_owner_q[b] <= cmd_owner_d[b];
        tag_owner_q[b] <= tag_owner_d[b];
      end
    end
  end

  // Two tags for one consumer is a protocol error; the lowest bank keeps the slot.
  always_comb begin
    resp_vld  = '0;
    tag_clash = '0;
    for (int c = 0; c < NCONSUMERS; c++) begin
      resp_dat[c] = '0;
    end
    for (int b = 0; b < NBANKS; b++) begin
      if (rd_pend_q[b]) begin
        if (resp_vld[tag_owner_q[b]]) begin
          tag_clash[tag_owner_q[b]] = 1'b1;
        end else begin
          resp_vld[tag_owner_q[b]] = 1'b1;
          resp_dat[tag_owner_q[b]] = bus.plm_rdata[b];
        end
      end
    end
  end

  a_one_tag_per_consumer: assert property (@(posedge clk) disable iff (!reset) tag_clash == '0);

  assign bus.ack        = ack_c;
  assign bus.out_en     = out_en_q;
  assign bus.resp_valid = resp_vld;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank_out
    assign bus.out[b] = out_q[b];
  end

  for (genvar c = 0; c < NCONSUMERS; c++) begin : g_resp_out
    assign bus.resp_data[c] = resp_dat[c];
  end
endmodule

// File: tb/tb_plm_bank_arbiter.sv
// Scoreboard bench for plm_bank_arbiter: 2x2 instance with a round-robin reference model,
// plus a single-bank instance exercised directly.
module tb_plm_bank_arbiter;
  localparam int AW = 4;
  localparam int VW = 8;
  localparam int RW = AW + VW + 2;
  localparam int CW = 3 + VW + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  plm_bank_arbiter_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(2), .NBANKS(2)) bif ();
  plm_bank_arbiter_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(2), .NBANKS(1)) bif1 ();

  plm_bank_arbiter #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(2), .NBANKS(2)) dut (
    .clk(clk), .reset(reset), .bus(bif.slave));
  plm_bank_arbiter #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(2), .NBANKS(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bif1.slave));

  typedef struct {
    int             due;
    logic [VW-1:0]  data;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int rc;
  int mptr [2];
  int b0_log [$];
  exp_t rq [2][$];
  logic [RW-2:0] stim [2][$];
  logic [1:0] exp_en;
  logic [CW-1:0] exp_out [2];
  logic [1:0] ack_seen = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Bank models: a read returns its own in-bank address one cycle after the command.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (bif.out_en[b]) bif.plm_rdata[b] <= VW'(bif.out[b][VW +: 3]);
    end
    if (bif1.out_en[0]) bif1.plm_rdata[0] <= VW'(bif1.out[0][VW +: 4]);
  end

  always @(negedge clk) begin
    logic [1:0] exp_ack, nxt_en, cand;
    logic [RW-1:0] r;
    int w;
    exp_t e;
    cyc++;
    if (!reset) begin
      check("rst_ack", bif.ack, 0);
      check("rst_out_en", bif.out_en, 0);
      check("rst_resp_valid", bif.resp_valid, 0);
      for (int b = 0; b < 2; b++) begin
        check("rst_out", bif.out[b], 0);
        check("rst_resp_data", bif.resp_data[b], 0);
        mptr[b] = 0;
        exp_out[b] = '0;
        rq[b].delete();
      end
      exp_en = '0;
    end else begin
      check("out_en", bif.out_en, exp_en);
      for (int b = 0; b < 2; b++) check("out", bif.out[b], exp_out[b]);
      for (int c = 0; c < 2; c++) begin
        if (bif.resp_valid[c]) begin
          if (rq[c].size() == 0) begin
            check("resp_unexpected", bif.resp_valid[c], 0);
          end else begin
            e = rq[c].pop_front();
            check("resp_cycle", cyc, e.due);
            check("resp_data", bif.resp_data[c], e.data);
            resp_cnt++;
          end
        end else if (rq[c].size() != 0 && rq[c][0].due <= cyc) begin
          check("resp_missing", bif.resp_valid[c], 1);
          void'(rq[c].pop_front());
        end
      end
      exp_ack = '0;
      nxt_en = '0;
      for (int b = 0; b < 2; b++) begin
        cand = '0;
        for (int c = 0; c < 2; c++) begin
          r = bif.requests[c];
          if (r[RW-1] && (int'(r[VW]) == b)) cand[c] = 1'b1;
        end
        if (cand != 2'b00) begin
          w = (cand == 2'b11) ? mptr[b] : (cand[1] ? 1 : 0);
          exp_ack[w] = 1'b1;
          mptr[b] = 1 - w;
          nxt_en[b] = 1'b1;
          r = bif.requests[w];
          exp_out[b] = {r[RW-2], r[VW+1 +: 3], r[VW-1:0]};
          if (!r[RW-2]) rq[w].push_back('{cyc + 2, VW'(r[VW+1 +: 3])});
          if (b == 0) b0_log.push_back(w);
        end
      end
      check("ack", bif.ack, exp_ack);
      exp_en = nxt_en;
    end
    ack_seen = bif.ack;
  end

  // One cycle of consumer behaviour: retire acked requests, present the next one.
  task automatic step();
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (bif.requests[c][RW-1] && ack_seen[c]) void'(stim[c].pop_front());
      bif.requests[c] = (stim[c].size() != 0) ? {1'b1, stim[c][0]} : '0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      bif.requests[c] = '0;
      bif1.requests[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Contention on bank 0 from reset: grants alternate starting with c0.
    b0_log.delete();
    for (int i = 0; i < 4; i++) begin
      stim[0].push_back({1'b0, AW'(2 * i), 8'h00});
      stim[1].push_back({1'b0, AW'(8 + 2 * i), 8'h00});
    end
    steps(12);
    check("cont_grants", b0_log.size(), 8);
    for (int i = 0; i < b0_log.size(); i++) check("cont_order", b0_log[i], i % 2);
    check("cont_resps", resp_cnt, 8);

    // Single write to bank 1.
    rc = resp_cnt;
    stim[0].push_back({1'b1, 4'h5, 8'hA5});
    step();
    step();
    check("wr_out_en", bif.out_en, 2'b10);
    check("wr_out1", bif.out[1], 12'hAA5);
    steps(3);
    check("wr_no_resp", resp_cnt, rc);

    // Parallel reads to both banks.
    rc = resp_cnt;
    stim[0].push_back({1'b0, 4'h2, 8'h00});
    stim[1].push_back({1'b0, 4'h3, 8'h00});
    step();
    step();
    check("par_out_en", bif.out_en, 2'b11);
    check("par_out0", bif.out[0], 12'h100);
    check("par_out1", bif.out[1], 12'h100);
    steps(3);
    check("par_resps", resp_cnt, rc + 2);

    // Pointer holds through idle cycles.
    b0_log.delete();
    stim[1].push_back({1'b0, 4'h4, 8'h00});
    steps(4);
    stim[0].push_back({1'b0, 4'h6, 8'h00});
    stim[1].push_back({1'b0, 4'h8, 8'h00});
    steps(6);
    check("hold_grants", b0_log.size(), 3);
    if (b0_log.size() == 3) begin
      check("hold_first", b0_log[0], 1);
      check("hold_second", b0_log[1], 0);
      check("hold_third", b0_log[2], 1);
    end

    // Reset lands while a read is in flight.
    rc = resp_cnt;
    stim[0].push_back({1'b0, 4'h2, 8'h00});
    step();
    step();
    check("mr_out_en", bif.out_en[0], 1);
    step();
    reset = 1'b0;
    steps(2);
    reset = 1'b1;
    check("mr_dropped", resp_cnt, rc);
    b0_log.delete();
    stim[1].push_back({1'b0, 4'h4, 8'h00});
    steps(5);
    check("mr_grants", b0_log.size(), 1);
    if (b0_log.size() == 1) check("mr_winner", b0_log[0], 1);
    check("mr_resp", resp_cnt, rc + 1);

    // Single-bank instance: both consumers read addr F continuously.
    bif1.requests[0] = {1'b1, 1'b0, 4'hF, 8'h00};
    bif1.requests[1] = {1'b1, 1'b0, 4'hF, 8'h00};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("nb1_ack", bif1.ack, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i >= 1) begin
        check("nb1_out_en", bif1.out_en, 1);
        check("nb1_out", bif1.out[0], 13'h0F00);
      end
      if (i >= 2) begin
        check("nb1_resp_valid", bif1.resp_valid, ((i - 2) % 2 == 0) ? 2'b01 : 2'b10);
        check("nb1_resp_data", bif1.resp_data[(i - 2) % 2], 8'h0F);
      end
    end
    @(posedge clk);
    #1;
    bif1.requests[0] = '0;
    bif1.requests[1] = '0;
    steps(3);

    check("drain_c0", rq[0].size(), 0);
    check("drain_c1", rq[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
